// File: rtl/score_pkg.sv
// score_pkg: FSM state encoding and BCD constants shared by the score controller
package score_pkg;
  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, CMP} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int DIGITS = 4;
  localparam logic [15:0] SCORE_MAX = 16'h9999;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: single BCD digit plus operand, returning the wrapped digit and carry
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
  assign co = sum > {1'b0, BCD_MAX};
  assign s = co ? 4'(sum - 5'd10) : sum[3:0];
endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: round-robin score-event arbiter feeding a digit-serial BCD accumulator with high-score tracking
module score_ctrl #(
  parameter int NREQ = 4,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [4*NREQ-1:0]     pts,
  input  logic                  clr,
  input  logic                  show_high,
  output logic [NREQ-1:0]       ack,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  busy,
  output logic                  sat
);
  import score_pkg::*;
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [4*DIGITS-1:0] score_q, score_d, high_q, high_d;
  logic sat_q, sat_d, clr_pend_q, clr_pend_d, carry_q, carry_d;
  logic [IW-1:0] last_q, last_d, gnt_idx;
  logic gnt_ok;
  logic [3:0] op_q, op_d, pts_sel, dig_in, dig_opnd, dig_sum;
  logic dig_co;
  logic [1:0] dig_sel;
  always_comb begin
    gnt_ok = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(last_q) + i) % NREQ]) begin
        gnt_ok = 1'b1;
        gnt_idx = IW'((int'(last_q) + i) % NREQ);
      end
    end
  end
  assign pts_sel = pts[{gnt_idx, 2'b00} +: 4];
  assign dig_sel = 2'(state_q - ADD0);
  assign dig_in = score_q[{dig_sel, 2'b00} +: 4];
  assign dig_opnd = state_q == ADD0 ? op_q : {3'b000, carry_q};
  bcd_digit_add u_add (.a(dig_in), .b(dig_opnd), .s(dig_sum), .co(dig_co));
  always_comb begin
    state_d = state_q;
    ack_d = '0;
    score_d = score_q;
    high_d = high_q;
    sat_d = sat_q;
    clr_pend_d = clr_pend_q | clr;
    carry_d = carry_q;
    last_d = last_q;
    op_d = op_q;
    case (state_q)
      IDLE: begin
        if (clr_pend_q || clr) begin
          score_d = '0;
          sat_d = 1'b0;
          clr_pend_d = 1'b0;
        end else if (gnt_ok) begin
          state_d = ADD0;
          ack_d[gnt_idx] = 1'b1;
          last_d = gnt_idx;
          op_d = pts_sel > BCD_MAX ? BCD_MAX : pts_sel;
        end
      end
      ADD0, ADD1, ADD2, ADD3: begin
        if (!sat_q) score_d[{dig_sel, 2'b00} +: 4] = dig_sum;
        carry_d = dig_co;
        state_d = state_q == ADD3 ? CMP : state_t'(state_q + 3'd1);
        // a carry out of the top digit pins the score at its ceiling
        if (state_q == ADD3 && dig_co && !sat_q) begin
          score_d = SCORE_MAX;
          sat_d = 1'b1;
        end
      end
      CMP: begin
        high_d = score_q > high_q ? score_q : high_q;
        carry_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q <= '0;
      score_q <= '0;
      high_q <= '0;
      sat_q <= 1'b0;
      clr_pend_q <= 1'b0;
      carry_q <= 1'b0;
      last_q <= IW'(NREQ - 1);
      op_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      score_q <= score_d;
      high_q <= high_d;
      sat_q <= sat_d;
      clr_pend_q <= clr_pend_d;
      carry_q <= carry_d;
      last_q <= last_d;
      op_q <= op_d;
    end
  end
  assign ack = ack_q;
  assign score = score_q;
  assign high = high_q;
  assign sat = sat_q;
  assign busy = state_q != IDLE;
  assign disp = show_high ? high_q : score_q;
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed stimulus with a queue-based scoreboard checked on every ack pulse
module tb_score_ctrl;
  typedef struct {
    logic [3:0]  ack;
    logic [15:0] score;
    logic        sat;
    logic [15:0] high;
    bit          abort;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, show_high = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] pts = '0;
  logic [3:0] ack;
  logic [15:0] score, high, disp;
  logic busy, sat;
  int checks = 0, errors = 0, cyc = 0;
  int m_sc = 0, m_hi = 0;
  bit m_sat = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  score_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .pts(pts), .clr(clr), .show_high(show_high),
    .ack(ack), .score(score), .high(high), .disp(disp), .busy(busy), .sat(sat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic push(input int src, input logic [3:0] p, input bit abort);
    exp_t e;
    if (!m_sat) m_sc += (p > 4'd9) ? 9 : int'(p);
    if (m_sc > 9999) begin
      m_sc = 9999;
      m_sat = 1'b1;
    end
    if (m_sc > m_hi) m_hi = m_sc;
    e.ack = 4'(1 << src);
    e.score = to_bcd(m_sc);
    e.sat = m_sat;
    e.high = to_bcd(m_hi);
    e.abort = abort;
    q.push_back(e);
  endtask
  task automatic wait_ack(input int src, output int at);
    int n = 0;
    while (ack[src] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ack[src] !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout src=%0d got=%b exp=1", src, ack[src]);
    end
    at = cyc;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got=%b exp=0", busy);
    end
  endtask
  task automatic add(input int src, input logic [3:0] p, input bit abort = 1'b0);
    int at;
    push(src, p, abort);
    pts[src*4 +: 4] = p;
    req[src] = 1'b1;
    @(negedge clk);
    wait_ack(src, at);
    req[src] = 1'b0;
  endtask
  task automatic do_clr();
    wait_idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_sc = 0;
    m_sat = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_sc = 0;
    m_hi = 0;
    m_sat = 1'b0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack got=%b exp=none", ack);
        end else begin
          mon_e = q.pop_front();
          chk("ack", {12'b0, ack}, {12'b0, mon_e.ack});
          repeat (4) @(negedge clk);
          if (!mon_e.abort) begin
            chk("score", score, mon_e.score);
            chk("sat", {15'b0, sat}, {15'b0, mon_e.sat});
          end
          @(negedge clk);
          if (!mon_e.abort) chk("high", high, mon_e.high);
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, at, prev;
    do_reset();
    chk("rst_score", score, 16'h0000);
    chk("rst_high", high, 16'h0000);
    chk("rst_sat", {15'b0, sat}, 16'h0000);
    chk("rst_ack", {12'b0, ack}, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    chk("rst_disp", disp, 16'h0000);
    push(0, 4'd7, 1'b0);
    pts[3:0] = 4'd7;
    req[0] = 1'b1;
    c = cyc;
    @(negedge clk);
    wait_ack(0, at);
    req[0] = 1'b0;
    chk("ack_latency", 16'(at - c), 16'd1);
    wait_idle();
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 5; k++) push(k % 4, 4'(k % 4 + 1), 1'b0);
    pts = 16'h4321;
    req = 4'hF;
    @(negedge clk);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(k % 4, at);
      if (k > 0) chk("grant_gap", 16'(at - prev), 16'd6);
      prev = at;
      if (k == 4) req = '0;
      @(negedge clk);
    end
    do_clr();
    for (int i = 0; i < 110; i++) add(1, i[0] ? 4'hC : 4'h9);
    add(1, 4'h5);
    add(3, 4'h5);
    add(2, 4'h0);
    do_clr();
    for (int i = 0; i < 1110; i++) add(0, 4'h9);
    add(2, 4'h8);
    add(0, 4'h9);
    add(3, 4'h1);
    do_clr();
    chk("clr_score", score, 16'h0000);
    chk("clr_sat", {15'b0, sat}, 16'h0000);
    chk("clr_high", high, 16'h9999);
    do_reset();
    repeat (5) add(0, 4'h9);
    add(0, 4'h5);
    do_clr();
    repeat (4) add(1, 4'h9);
    add(1, 4'h6);
    wait_idle();
    chk("pre_score", score, 16'h0042);
    chk("pre_high", high, 16'h0050);
    add(2, 4'h1);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_sc = 0;
    repeat (3) @(negedge clk);
    chk("pend_clr_score", score, 16'h0000);
    chk("pend_clr_high", high, 16'h0050);
    push(1, 4'h3, 1'b0);
    pts[7:4] = 4'h3;
    clr = 1'b1;
    req[1] = 1'b1;
    c = cyc;
    @(negedge clk);
    clr = 1'b0;
    wait_ack(1, at);
    req[1] = 1'b0;
    chk("clr_req_latency", 16'(at - c), 16'd2);
    wait_idle();
    @(negedge clk);
    do_reset();
    add(0, 4'h9);
    add(2, 4'h5, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_score", score, 16'h0000);
    chk("mid_rst_high", high, 16'h0000);
    chk("mid_rst_sat", {15'b0, sat}, 16'h0000);
    chk("mid_rst_ack", {12'b0, ack}, 16'h0000);
    chk("mid_rst_busy", {15'b0, busy}, 16'h0000);
    chk("mid_rst_disp", disp, 16'h0000);
    reset = 1'b0;
    m_sc = 0;
    m_hi = 0;
    m_sat = 1'b0;
    repeat (6) @(negedge clk);
    add(0, 4'h8);
    do_clr();
    add(1, 4'h3);
    wait_idle();
    show_high = 1'b1;
    #1;
    chk("disp_high", disp, 16'h0008);
    show_high = 1'b0;
    #1;
    chk("disp_score", disp, 16'h0003);
    repeat (8) @(negedge clk);
    chk("queue_empty", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameter NREQ, default 4, number of score-event requesters.
REQ-002 Parameter DIGITS, fixed at 4, number of BCD digits in the score.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req  in  NREQ  per-source score request; level, held by the source until acked.
REQ-007 pts  in  4*NREQ  per-source BCD point value; source i uses bits [4i+3:4i].
REQ-008 clr  in  1  one-cycle pulse that clears the current score (game restart).
REQ-009 show_high  in  1  display select: 1 = high score, 0 = current score.
REQ-010 ack  out  NREQ  one-hot grant pulse, one cycle.
REQ-011 score  out  16  current score, 4 packed BCD digits, digit 0 in [3:0].
REQ-012 high  out  16  high score, packed BCD.
REQ-013 disp  out  16  BCD word for the four hex_decoder instances.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 sat  out  1  score has saturated at 9999.

Function
REQ-016 The FSM SHALL have states IDLE, ADD0, ADD1, ADD2, ADD3 and CMP.
REQ-017 In IDLE, a pending clear SHALL zero score and sat, grant nothing, and stay in IDLE.
REQ-018 In IDLE with no pending clear and any req bit set, the FSM SHALL pick one source by round-robin, latch its pts and go to ADD0.
REQ-019 Round-robin SHALL search from last+1 modulo NREQ; last updates to the granted index.
REQ-020 ack[g] SHALL be high only during the ADD0 cycle of grant g.
REQ-021 A latched pts value above 9 SHALL be clamped to 9.
REQ-022 ADDk SHALL add an operand to score digit k: latched pts for k=0, otherwise the carry from digit k-1.
REQ-023 In ADDk, a digit sum above 9 SHALL store sum-10 and set carry 1; otherwise it stores sum and sets carry 0.
REQ-024 If ADD3 produces a carry-out, score SHALL be set to 16'h9999 and sat set to 1.
REQ-025 While sat is 1, requests SHALL still be granted, and score SHALL remain 16'h9999.
REQ-026 CMP SHALL load high from score when score is greater than high (BCD compares as unsigned), then return to IDLE.
REQ-027 Latency: a req sampled in IDLE at edge 0 gives ack in cycle 1, the updated score from cycle 5, the updated high from cycle 6, and a new grant at the earliest in cycle 6.
REQ-028 A clr pulse in any state SHALL set a clear-pending flag; the flag is consumed at the next IDLE cycle.
REQ-029 An add already in progress SHALL complete before a pending clear is applied.
REQ-030 clr SHALL NOT affect high.
REQ-031 If clr and req are both present in IDLE, the clear SHALL win; the req is granted in the following IDLE cycle.
REQ-032 A pts value of 0 SHALL be granted normally and leave score unchanged.
REQ-033 disp SHALL equal high when show_high is 1, otherwise score (combinational).

Reset
REQ-034 Reset SHALL force state IDLE, score 0, high 0, sat 0, ack 0, clear-pending 0 and carry 0.
REQ-035 Reset SHALL set last to NREQ-1 so that source 0 has first priority.
REQ-036 Reset asserted mid-operation SHALL abandon the add, with all reset values visible in the next cycle.

Structure
REQ-037 Package score_pkg SHALL hold the FSM state encoding, BCD_MAX = 9, DIGITS = 4 and SCORE_MAX = 16'h9999.
REQ-038 One sub-module, bcd_digit_add, SHALL take a 4-bit digit and a 4-bit operand and return a 4-bit digit and a 1-bit carry.
REQ-039 The block SHALL instantiate bcd_digit_add once and share it across ADD0 to ADD3.

Verification
REQ-040 Reset, then req[0] held with pts0=7 -> ack[0] in cycle 1, score=16'h0007 in cycle 5, high=16'h0007 in cycle 6.
REQ-041 Preload score 16'h0995, add pts=5 -> digits ripple over ADD0 to ADD2, final score=16'h1000, sat=0.
REQ-042 Preload score 16'h9998, add 9 -> score=16'h9999, sat=1; a further add of 1 -> ack asserted, score stays 16'h9999.
REQ-043 From reset, req[3:0] all held with pts 1,2,3,4 -> ack order 0,1,2,3 then 0 again; after four grants score=16'h0010, and grants are 6 cycles apart.
REQ-044 Score 16'h0042 and high 16'h0050, then clr pulsed during ADD2 of an add of 1 -> score=16'h0043 after CMP, score=0 on the next IDLE cycle, high stays 16'h0050; clr with req in the same IDLE cycle -> req acked one cycle later.
REQ-045 reset asserted during ADD1 -> all outputs 0 the next cycle; toggling show_high switches disp between score and high in the same cycle.
